qpp_addr_gen: RTL and testbench
===============================

QPP_ADDR_GEN -- requirements
Module: qpp_addr_gen

Interface
REQ-001 SHALL have parameter N, default 10: address/length width in bits.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: one-cycle request to begin a frame; sampled only in IDLE.
REQ-005 SHALL have port k_len, input, N: frame length K; legal range 2..2^N-1.
REQ-006 SHALL have port f1, input, N: QPP linear coefficient.
REQ-007 SHALL have port f2, input, N: QPP quadratic coefficient.
REQ-008 SHALL have port abort, input, 1: cancels the current frame.
REQ-009 SHALL have port addr, output, N: interleaved address pi(i) = (f1*i + f2*i^2) mod K.
REQ-010 SHALL have port addr_idx, output, N: sequential index i of the current addr.
REQ-011 SHALL have port addr_valid, output, 1: addr/addr_idx/addr_last valid.
REQ-012 SHALL have port addr_ready, input, 1: downstream interleaver accepts the output.
REQ-013 SHALL have port addr_last, output, 1: asserted with i = K-1.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle pulse after the last address handshake.
REQ-016 SHALL have port cfg_err, output, 1: one-cycle pulse when start is rejected.

Function
REQ-017 SHALL implement FSM states IDLE, INIT, RUN.
REQ-018 IDLE + start with legal config SHALL latch k_len, f1 and f2 and go to INIT; latched values SHALL be used for the whole frame.
REQ-019 Config SHALL be illegal if k_len < 2, f1 >= k_len or f2 >= k_len; start with illegal config SHALL pulse cfg_err the next cycle and remain in IDLE.
REQ-020 INIT, one cycle, SHALL compute g = (f1+f2) mod K, step d = (2*f2) mod K, f = 0, i = 0, then go to RUN.
REQ-021 In RUN, addr_valid SHALL be high; first addr_valid SHALL occur 2 cycles after the start cycle.
REQ-022 A handshake (addr_valid & addr_ready) SHALL update f <= (f+g) mod K, g <= (g+d) mod K, i <= i+1.
REQ-023 All modular adds SHALL use N+1-bit intermediates with a single conditional subtract of K; no multipliers or dividers.
REQ-024 While addr_ready is low, addr, addr_idx and addr_last SHALL hold stable.
REQ-025 Full throughput: one address per cycle while addr_ready is held high.
REQ-026 The handshake with addr_last SHALL go to IDLE and pulse done in the following cycle; busy SHALL be low in that cycle.
REQ-027 start outside IDLE SHALL be ignored, including start in the done cycle; start SHALL be accepted the cycle after done.
REQ-028 abort in INIT or RUN SHALL return to IDLE the next cycle, with addr_valid low and no done pulse; abort has priority over a simultaneous handshake.
REQ-029 abort in IDLE SHALL be ignored; abort together with start in IDLE SHALL reject the start, with no cfg_err.

Reset
REQ-030 rst SHALL force IDLE; addr, addr_idx, addr_valid, addr_last, busy, done and cfg_err SHALL be 0, along with internal f, g, d, i and the latched config.
REQ-031 rst SHALL take priority over start, abort and the handshake; rst mid-frame SHALL abandon the frame with no done.

Verification
REQ-032 K=8, f1=3, f2=2, addr_ready=1 -> addr sequence 0,5,6,3,4,1,2,7; addr_last on 7; done 1 cycle later; 8 consecutive valid cycles.
REQ-033 K=40, f1=3, f2=10 -> first addr values 0,13,6,19,12; full frame is a permutation of 0..39.
REQ-034 K=8 with addr_ready toggled pseudo-randomly -> same sequence as REQ-032; outputs stable during stalls.
REQ-035 start with f1=8, K=8 -> cfg_err pulse, busy stays 0, no addr_valid.
REQ-036 abort at i=3, then start the next cycle -> new frame restarts at addr 0, addr_idx 0, no done for the aborted frame.
REQ-037 rst asserted at i=5 -> all outputs 0 the next cycle; subsequent start runs a clean frame.

Source files
------------

// File: rtl/qpp_addr_gen.sv
// rtl/qpp_addr_gen.sv - QPP interleaver address generator
// Produces pi(i) = (f1*i + f2*i^2) mod K incrementally, one address per handshake.
module qpp_addr_gen #(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] k_len,
    input  logic [N-1:0] f1,
    input  logic [N-1:0] f2,
    input  logic         abort,
    output logic [N-1:0] addr,
    output logic [N-1:0] addr_idx,
    output logic         addr_valid,
    input  logic         addr_ready,
    output logic         addr_last,
    output logic         busy,
    output logic         done,
    output logic         cfg_err
);

    typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [N-1:0] k_q, k_d;
    logic [N-1:0] f1_q, f1_d;
    logic [N-1:0] f2_q, f2_d;
    logic [N-1:0] f_q, f_d;
    logic [N-1:0] g_q, g_d;
    logic [N-1:0] d_q, d_d;
    logic [N-1:0] i_q, i_d;
    logic         done_q, done_d;
    logic         cfg_err_q, cfg_err_d;

    logic         cfg_ok;
    logic         at_last;
    logic         hs;

    // Both operands are already reduced below k, so one conditional subtract suffices.
    function automatic logic [N-1:0] mod_add(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [N-1:0] k);
        logic [N:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, k}) begin
            s = s - {1'b0, k};
        end
        return s[N-1:0];
    endfunction

    assign cfg_ok  = (k_len > ONE) && (f1 < k_len) && (f2 < k_len);
    assign at_last = (i_q == (k_q - ONE));
    assign hs      = (state_q == RUN) && addr_ready;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        f1_d      = f1_q;
        f2_d      = f2_q;
        f_d       = f_q;
        g_d       = g_q;
        d_d       = d_q;
        i_d       = i_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                // The done cycle is IDLE but still closes the previous frame.
                if (start && !abort && !done_q) begin
                    if (cfg_ok) begin
                        k_d     = k_len;
                        f1_d    = f1;
                        f2_d    = f2;
                        state_d = INIT;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            INIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    g_d     = mod_add(f1_q, f2_q, k_q);
                    d_d     = mod_add(f2_q, f2_q, k_q);
                    f_d     = '0;
                    i_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (hs) begin
                    f_d = mod_add(f_q, g_q, k_q);
                    g_d = mod_add(g_q, d_q, k_q);
                    i_d = i_q + ONE;
                    if (at_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            f1_q      <= '0;
            f2_q      <= '0;
            f_q       <= '0;
            g_q       <= '0;
            d_q       <= '0;
            i_q       <= '0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            f1_q      <= f1_d;
            f2_q      <= f2_d;
            f_q       <= f_d;
            g_q       <= g_d;
            d_q       <= d_d;
            i_q       <= i_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign addr       = f_q;
    assign addr_idx   = i_q;
    assign addr_valid = (state_q == RUN);
    assign addr_last  = (state_q == RUN) && at_last;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_qpp_addr_gen.sv
// tb/tb_qpp_addr_gen.sv - scoreboard bench for qpp_addr_gen
module tb_qpp_addr_gen;

    logic       clk = 1'b0;
    logic       rst, start, abort, addr_ready;
    logic [9:0] k_len, f1, f2;
    logic [9:0] addr, addr_idx;
    logic       addr_valid, addr_last, busy, done, cfg_err;

    typedef struct {
        logic [9:0] a;
        logic [9:0] idx;
        logic       last;
    } exp_t;

    exp_t       sb[$];
    logic [9:0] got[$];
    int         checks = 0;
    int         errors = 0;

    qpp_addr_gen #(.N(10)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .f1(f1), .f2(f2),
        .abort(abort), .addr(addr), .addr_idx(addr_idx), .addr_valid(addr_valid),
        .addr_ready(addr_ready), .addr_last(addr_last), .busy(busy), .done(done),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected addresses come straight from the closed-form QPP polynomial.
    task automatic push_model(input int k, input int c1, input int c2);
        exp_t e;
        for (int i = 0; i < k; i++) begin
            e.a    = 10'((c1 * i + c2 * i * i) % k);
            e.idx  = 10'(i);
            e.last = (i == k - 1);
            sb.push_back(e);
        end
    endtask

    task automatic start_frame(input int k, input int c1, input int c2);
        k_len = 10'(k);
        f1    = 10'(c1);
        f2    = 10'(c2);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || addr_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL init_cycle busy=%b valid=%b done=%b, want busy=1 valid=0 done=0",
                     busy, addr_valid, done);
        end
        step();
        checks++;
        if (addr_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_valid_latency valid=%b, want 1", addr_valid);
        end
    endtask

    task automatic drain(input bit rnd, input int k);
        int         cycles = 0;
        bit         fin = 0;
        bit         stalled = 0;
        bit         rdy;
        logic [9:0] sa, si;
        logic       sl;
        exp_t       e;
        got.delete();
        while (!fin && cycles < 4000) begin
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                checks++;
                if (addr !== sa || addr_idx !== si || addr_last !== sl) begin
                    errors++;
                    $display("FAIL stall_hold addr=%0d idx=%0d last=%b, want addr=%0d idx=%0d last=%b",
                             addr, addr_idx, addr_last, sa, si, sl);
                end
            end
            checks++;
            if (addr_valid !== 1'b1 || sb.size() == 0) begin
                errors++;
                $display("FAIL valid_run valid=%b queued=%0d, want valid=1 with data queued",
                         addr_valid, sb.size());
                break;
            end
            stalled = 0;
            if (rdy) begin
                e = sb.pop_front();
                got.push_back(addr);
                checks++;
                if (addr !== e.a || addr_idx !== e.idx || addr_last !== e.last) begin
                    errors++;
                    $display("FAIL addr_out addr=%0d idx=%0d last=%b, want addr=%0d idx=%0d last=%b",
                             addr, addr_idx, addr_last, e.a, e.idx, e.last);
                end
                if (e.last) fin = 1;
            end else begin
                stalled = 1;
                sa = addr;
                si = addr_idx;
                sl = addr_last;
            end
            addr_ready = rdy;
            step();
            cycles++;
        end
        addr_ready = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL frame_end finished=0 after %0d cycles, want finished=1", cycles);
        end else if (done !== 1'b1 || busy !== 1'b0 || addr_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse done=%b busy=%b valid=%b, want done=1 busy=0 valid=0",
                     done, busy, addr_valid);
        end
        if (!rnd) begin
            checks++;
            if (cycles != k) begin
                errors++;
                $display("FAIL throughput cycles=%0d, want %0d", cycles, k);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        k_len = 10'd8;
        f1 = 10'd3;
        f2 = 10'd2;
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        checks++;
        if (addr !== 0 || addr_idx !== 0 || addr_valid !== 0 || addr_last !== 0 ||
            busy !== 0 || done !== 0 || cfg_err !== 0) begin
            errors++;
            $display("FAIL reset_state addr=%0d idx=%0d v=%b l=%b busy=%b done=%b err=%b, want all 0",
                     addr, addr_idx, addr_valid, addr_last, busy, done, cfg_err);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_k8_seq();
        int   seq8[8];
        exp_t e;
        seq8 = '{0, 5, 6, 3, 4, 1, 2, 7};
        for (int i = 0; i < 8; i++) begin
            e.a    = 10'(seq8[i]);
            e.idx  = 10'(i);
            e.last = (i == 7);
            sb.push_back(e);
        end
        start_frame(8, 3, 2);
        drain(0, 8);
        step();
    endtask

    task automatic test_k40();
        int  first5[5];
        bit  seen[40];
        int  distinct = 0;
        first5 = '{0, 13, 6, 19, 12};
        push_model(40, 3, 10);
        start_frame(40, 3, 10);
        drain(0, 40);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got.size() <= i || got[i] !== 10'(first5[i])) begin
                errors++;
                $display("FAIL k40_prefix i=%0d got=%0d, want %0d", i,
                         (got.size() > i) ? int'(got[i]) : -1, first5[i]);
            end
        end
        foreach (got[j]) begin
            if (got[j] < 40 && !seen[got[j]]) begin
                seen[got[j]] = 1;
                distinct++;
            end
        end
        checks++;
        if (distinct != 40) begin
            errors++;
            $display("FAIL k40_permutation distinct=%0d, want 40", distinct);
        end
        step();
    endtask

    task automatic test_k8_stall();
        push_model(8, 3, 2);
        start_frame(8, 3, 2);
        drain(1, 8);
        step();
    endtask

    task automatic test_cfg_err();
        k_len = 10'd8;
        f1 = 10'd8;
        f2 = 10'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_f1 err=%b busy=%b, want err=1 busy=0", cfg_err, busy);
        end
        step();
        checks++;
        if (cfg_err !== 1'b0 || busy !== 1'b0 || addr_valid !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_after err=%b busy=%b valid=%b, want all 0", cfg_err, busy, addr_valid);
        end
        k_len = 10'd1;
        f1 = 10'd0;
        f2 = 10'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_k1 err=%b busy=%b, want err=1 busy=0", cfg_err, busy);
        end
        k_len = 10'd8;
        f1 = 10'd3;
        f2 = 10'd2;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (cfg_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_start err=%b busy=%b, want err=0 busy=0", cfg_err, busy);
        end
        step();
    endtask

    task automatic test_abort();
        exp_t e;
        push_model(8, 3, 2);
        start_frame(8, 3, 2);
        for (int j = 0; j < 3; j++) begin
            e = sb.pop_front();
            checks++;
            if (addr !== e.a || addr_idx !== e.idx) begin
                errors++;
                $display("FAIL abort_pre addr=%0d idx=%0d, want addr=%0d idx=%0d", addr, addr_idx, e.a, e.idx);
            end
            addr_ready = 1'b1;
            step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        addr_ready = 1'b0;
        checks++;
        if (addr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_exit valid=%b busy=%b done=%b, want all 0", addr_valid, busy, done);
        end
        sb.delete();
        push_model(8, 3, 2);
        start_frame(8, 3, 2);
        drain(0, 8);
        step();
    endtask

    task automatic test_rst_mid();
        push_model(16, 5, 4);
        start_frame(16, 5, 4);
        addr_ready = 1'b1;
        for (int j = 0; j < 5; j++) step();
        addr_ready = 1'b0;
        checks++;
        if (addr_idx !== 10'd5) begin
            errors++;
            $display("FAIL rst_mid_idx idx=%0d, want 5", addr_idx);
        end
        rst = 1'b1;
        addr_ready = 1'b1;
        step();
        rst = 1'b0;
        addr_ready = 1'b0;
        checks++;
        if (addr !== 0 || addr_idx !== 0 || addr_valid !== 0 || addr_last !== 0 ||
            busy !== 0 || done !== 0 || cfg_err !== 0) begin
            errors++;
            $display("FAIL rst_mid_state addr=%0d idx=%0d v=%b l=%b busy=%b done=%b err=%b, want all 0",
                     addr, addr_idx, addr_valid, addr_last, busy, done, cfg_err);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_nodone done=%b busy=%b, want 0 0", done, busy);
        end
        sb.delete();
        push_model(8, 3, 2);
        start_frame(8, 3, 2);
        drain(0, 8);
        step();
    endtask

    task automatic test_done_start();
        push_model(8, 3, 2);
        start_frame(8, 3, 2);
        drain(0, 8);
        k_len = 10'd8;
        f1 = 10'd3;
        f2 = 10'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done busy=%b err=%b, want 0 0", busy, cfg_err);
        end
        step();
        checks++;
        if (addr_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done_late valid=%b busy=%b, want 0 0", addr_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        push_model(8, 3, 2);
        start_frame(8, 3, 2);
        drain(0, 8);
        step();
        push_model(40, 3, 10);
        start_frame(40, 3, 10);
        drain(0, 40);
        step();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        addr_ready = 1'b0;
        k_len = '0;
        f1 = '0;
        f2 = '0;
        test_reset();
        test_k8_seq();
        test_k40();
        test_k8_stall();
        test_cfg_err();
        test_abort();
        test_rst_mid();
        test_done_start();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
